// File: rtl/adc_fifo_reader.sv
// rtl/adc_fifo_reader.sv - drains 32-bit ADC words from the storage FIFO into UART frames
// Frame: HEADER, four bytes per word MSB-first, XOR checksum of the data bytes.
module adc_fifo_reader #(
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter logic [15:0] MAX_WORDS = 16'd2048
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Abort,
    input  logic        FifoEmpty,
    input  logic [31:0] FifoData,
    output logic        FifoRdEn,
    input  logic        TxBusy,
    output logic [7:0]  TxData,
    output logic        TxWrite,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] WordCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_RD, S_LAT, S_BYTE, S_CHK, S_GAP, S_FIN
    } state_t;

    state_t      state_q, state_d, ret_q, ret_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        fresh_q, fresh_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] wc_q, wc_d;
    logic        rden_q, rden_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        txwr_q, txwr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;
    logic        accept;
    logic        rd_stop;

    assign accept  = Start && !busy_q;
    assign rd_stop = FifoEmpty || (wc_q == MAX_WORDS);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            word_q   <= 32'h0;
            idx_q    <= 2'd0;
            fresh_q  <= 1'b0;
            csum_q   <= 8'h00;
            wc_q     <= 16'h0;
            rden_q   <= 1'b0;
            txdata_q <= 8'h00;
            txwr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            fresh_q  <= fresh_d;
            csum_q   <= csum_d;
            wc_q     <= wc_d;
            rden_q   <= rden_d;
            txdata_q <= txdata_d;
            txwr_q   <= txwr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The header goes out straight from IDLE when the UART is free; HDR only waits out a busy UART.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        if (Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    if (!TxBusy) begin
                        state_d = S_GAP;
                        ret_d   = S_RD;
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_HDR: if (!TxBusy) begin
                    state_d = S_GAP;
                    ret_d   = S_RD;
                end
                S_RD:   state_d = rd_stop ? S_CHK : S_LAT;
                S_LAT:  state_d = S_BYTE;
                S_BYTE: if (!TxBusy) begin
                    state_d = S_GAP;
                    ret_d   = (idx_q == 2'd0) ? S_RD : S_BYTE;
                end
                S_GAP:  state_d = ret_q;
                S_CHK:  if (!TxBusy) state_d = S_FIN;
                S_FIN:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The strobe is registered, so read data arrives during the first BYTE cycle and is used directly.
    always_comb begin
        cur_word = fresh_q ? FifoData : word_q;
        case (idx_q)
            2'd3:    cur_byte = cur_word[31:24];
            2'd2:    cur_byte = cur_word[23:16];
            2'd1:    cur_byte = cur_word[15:8];
            default: cur_byte = cur_word[7:0];
        endcase
    end

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        fresh_d  = fresh_q;
        csum_d   = csum_q;
        wc_d     = wc_q;
        rden_d   = 1'b0;
        txdata_d = txdata_q;
        txwr_d   = 1'b0;
        done_d   = 1'b0;
        if (!Abort) begin
            case (state_q)
                S_IDLE: if (accept) begin
                    wc_d    = 16'h0;
                    csum_d  = 8'h00;
                    idx_d   = 2'd0;
                    fresh_d = 1'b0;
                    if (!TxBusy) begin
                        txwr_d   = 1'b1;
                        txdata_d = HEADER;
                    end
                end
                S_HDR: if (!TxBusy) begin
                    txwr_d   = 1'b1;
                    txdata_d = HEADER;
                end
                S_RD:  rden_d = !rd_stop;
                S_LAT: begin
                    idx_d   = 2'd3;
                    fresh_d = 1'b1;
                end
                S_BYTE: begin
                    if (fresh_q) begin
                        word_d  = FifoData;
                        fresh_d = 1'b0;
                    end
                    if (!TxBusy) begin
                        txwr_d   = 1'b1;
                        txdata_d = cur_byte;
                        csum_d   = csum_q ^ cur_byte;
                        if (idx_q == 2'd0) wc_d = wc_q + 16'd1;
                        else               idx_d = idx_q - 2'd1;
                    end
                end
                S_CHK: if (!TxBusy) begin
                    txwr_d   = 1'b1;
                    txdata_d = csum_q;
                end
                S_FIN:  done_d = 1'b1;
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE) || (state_q == S_FIN && !Abort);
    end

    assign FifoRdEn  = rden_q;
    assign TxData    = txdata_q;
    assign TxWrite   = txwr_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign WordCount = wc_q;

endmodule

// File: tb/tb_adc_fifo_reader.sv
// tb/tb_adc_fifo_reader.sv - directed bench with FIFO/UART models and a frame scoreboard
module tb_adc_fifo_reader;

    localparam int MAXW = 3;

    logic        Clock, Reset_n, Start, Abort, FifoEmpty, FifoRdEn, TxBusy, TxWrite, Busy, Done;
    logic [31:0] FifoData;
    logic [7:0]  TxData;
    logic [15:0] WordCount;

    adc_fifo_reader #(.HEADER(8'hA5), .MAX_WORDS(16'd3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
        .FifoEmpty(FifoEmpty), .FifoData(FifoData), .FifoRdEn(FifoRdEn),
        .TxBusy(TxBusy), .TxData(TxData), .TxWrite(TxWrite),
        .Busy(Busy), .Done(Done), .WordCount(WordCount)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          rden_cnt = 0;
    int          done_cnt = 0;
    int          exp_wc = 0;
    bit          frame_open = 0;
    int          uart_k = 0;
    int          ucnt = 0;
    logic        prev_busy = 0;

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Storage FIFO: data appears the cycle after the read strobe.
    always @(posedge Clock) begin
        if (FifoRdEn && Reset_n) begin
            #1;
            if (fifo_q.size() > 0) FifoData = fifo_q.pop_front();
        end else begin
            #1;
        end
        FifoEmpty = (fifo_q.size() == 0);
    end

    // UART: busy for uart_k cycles starting the cycle after a write.
    always @(posedge Clock) begin
        if (TxWrite) ucnt = uart_k;
        else if (ucnt > 0) ucnt--;
        #1 TxBusy = (ucnt != 0);
    end

    always @(negedge Clock) begin
        if (TxWrite) begin
            chk("tx_while_uart_busy", prev_busy, 0);
            chk("txwrite_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("tx_byte", TxData, exp_q[0]);
                void'(exp_q.pop_front());
            end
            got_q.push_back(TxData);
        end
        if (FifoRdEn) rden_cnt++;
        if (Done) begin
            chk("done_frame_open", frame_open, 1);
            chk("done_all_bytes_sent", exp_q.size(), 0);
            chk("done_wordcount", WordCount, exp_wc);
            done_cnt++;
            frame_open = 0;
        end
        prev_busy = TxBusy;
    end

    task automatic prep_frame();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        got_q.delete();
        x = 8'h00;
        n = (fifo_q.size() < MAXW) ? fifo_q.size() : MAXW;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            w = fifo_q[i];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(x);
        exp_wc = n;
        frame_open = 1;
        rden_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame();
        logic bsy;
        prep_frame();
        @(negedge Clock);
        Start = 1;
        bsy = TxBusy;
        @(negedge Clock);
        Start = 0;
        chk("start_busy_next_cycle", Busy, 1);
        chk("start_wordcount_cleared", WordCount, 0);
        if (!bsy) chk("start_header_next_cycle", TxWrite, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(negedge Clock);
            #2;
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        @(negedge Clock);
        chk("busy_low_after_done", Busy, 0);
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (got_q.size() < n && t < 2000) begin
            @(negedge Clock);
            #2;
            t++;
        end
        chk("bytes_reached", got_q.size() >= n, 1);
    endtask

    logic [7:0] lit2 [10];

    initial begin
        int t;
        lit2 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'h04};
        Reset_n = 0; Start = 0; Abort = 0; FifoData = 0; FifoEmpty = 1; TxBusy = 0;
        repeat (3) @(negedge Clock);
        chk("rst_fifordnen", FifoRdEn, 0);
        chk("rst_txwrite", TxWrite, 0);
        chk("rst_txdata", TxData, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_wordcount", WordCount, 0);
        Reset_n = 1;
        repeat (2) @(negedge Clock);

        // Empty FIFO: header then zero checksum
        start_frame();
        wait_done();
        chk("empty_len", got_q.size(), 2);
        chk("empty_hdr", got_q[0], 8'hA5);
        chk("empty_csum", got_q[1], 8'h00);
        chk("empty_rden", rden_cnt, 0);
        chk("empty_wc", WordCount, 0);
        repeat (5) @(negedge Clock);
        chk("empty_single_done", done_cnt, 1);

        // Two words with a slow UART
        uart_k = 10;
        fifo_q.push_back(32'h01020304);
        fifo_q.push_back(32'hF0E0D0C0);
        repeat (2) @(negedge Clock);
        start_frame();
        wait_done();
        chk("two_len", got_q.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < got_q.size()) chk("two_literal_byte", got_q[i], lit2[i]);
        chk("two_wc", WordCount, 2);
        chk("two_rden", rden_cnt, 2);

        // Word limit of 3 with five words queued
        uart_k = 1;
        fifo_q.push_back(32'h11223344);
        fifo_q.push_back(32'h55667788);
        fifo_q.push_back(32'h99AABBCC);
        fifo_q.push_back(32'hDDEEFF00);
        fifo_q.push_back(32'h12345678);
        repeat (2) @(negedge Clock);
        start_frame();
        wait_done();
        chk("max_len", got_q.size(), 14);
        if (got_q.size() == 14) chk("max_csum", got_q[13], 8'hCC);
        chk("max_wc", WordCount, 3);
        chk("max_rden", rden_cnt, 3);
        chk("max_remaining", fifo_q.size(), 2);
        start_frame();
        wait_done();
        chk("rest_len", got_q.size(), 10);
        if (got_q.size() == 10) chk("rest_csum", got_q[9], 8'hC4);
        chk("rest_wc", WordCount, 2);

        // Abort one cycle after the second data byte
        uart_k = 0;
        fifo_q.push_back(32'hA1B2C3D4);
        fifo_q.push_back(32'h0F1E2D3C);
        repeat (2) @(negedge Clock);
        start_frame();
        wait_bytes(3);
        @(negedge Clock);
        Abort = 1;
        exp_q.delete();
        frame_open = 0;
        @(negedge Clock);
        Abort = 0;
        chk("abort_busy_low", Busy, 0);
        repeat (20) @(negedge Clock);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_more_bytes", got_q.size(), 3);
        start_frame();
        wait_done();
        chk("after_abort_hdr", got_q[0], 8'hA5);
        chk("after_abort_wc", WordCount, 1);
        chk("after_abort_fifo_empty", fifo_q.size(), 0);

        // Asynchronous reset mid-word
        uart_k = 1;
        fifo_q.push_back(32'hCAFEBABE);
        fifo_q.push_back(32'h00000001);
        repeat (2) @(negedge Clock);
        start_frame();
        wait_bytes(2);
        @(negedge Clock);
        #1 Reset_n = 0;
        exp_q.delete();
        frame_open = 0;
        #1;
        chk("arst_fifordnen", FifoRdEn, 0);
        chk("arst_txwrite", TxWrite, 0);
        chk("arst_txdata", TxData, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_wordcount", WordCount, 0);
        repeat (2) @(negedge Clock);
        Reset_n = 1;
        repeat (3) @(negedge Clock);
        chk("arst_idle_after_release", Busy, 0);
        start_frame();
        wait_done();
        chk("arst_restart_hdr", got_q[0], 8'hA5);

        // Start held high for the whole frame
        uart_k = 0;
        fifo_q.delete();
        fifo_q.push_back(32'h5A5A5A5A);
        repeat (2) @(negedge Clock);
        prep_frame();
        @(negedge Clock);
        Start = 1;
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(negedge Clock);
            #2;
            t++;
        end
        Start = 0;
        chk("held_done_seen", done_cnt, 1);
        repeat (30) @(negedge Clock);
        chk("held_single_frame", done_cnt, 1);
        chk("held_len", got_q.size(), 6);
        chk("held_busy_low", Busy, 0);

        // Start and Abort together while idle
        done_cnt = 0;
        got_q.delete();
        @(negedge Clock);
        Start = 1;
        Abort = 1;
        @(negedge Clock);
        Start = 0;
        Abort = 0;
        chk("start_abort_busy", Busy, 0);
        repeat (20) @(negedge Clock);
        chk("start_abort_no_bytes", got_q.size(), 0);
        chk("start_abort_no_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
